// File: rtl/tea_cipher_core_if.sv
// Handshake, data and configuration bundle for tea_cipher_core.
interface tea_cipher_core_if #(
  parameter int W = 32
) ();
  logic             mode;
  logic [2:0]       round;
  logic [W-1:0]     delta;
  logic [4*W-1:0]   key;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_data;
  logic             busy;

  modport master (
    output mode, round, delta, key, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  mode, round, delta, key, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/tea_cipher_core.sv
// Iterative TEA encrypt/decrypt core: one round per clock, valid/ready on both
// sides, with a one-entry output register so a new block can run while the
// previous result is still waiting to be taken.
module tea_cipher_core #(
  parameter int W   = 32,
  parameter int SHL = 4,
  parameter int SHR = 5
) (
  input logic              clk,
  input logic              rst,
  tea_cipher_core_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [W-1:0]     delta_q, delta_d;
  logic [4*W-1:0]   key_q, key_d;
  logic             mode_q, mode_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2*W-1:0]   out_q, out_d;
  logic             ov_q, ov_d;

  logic [W-1:0]     k0, k1, k2, k3;
  logic [W-1:0]     esum, ex, ey, dsum, dx, dy;
  logic [W-1:0]     rx, ry, rsum;
  logic             out_free;

  assign k0 = key_q[W-1:0];
  assign k1 = key_q[2*W-1:W];
  assign k2 = key_q[3*W-1:2*W];
  assign k3 = key_q[4*W-1:3*W];

  function automatic logic [W-1:0] mix(input logic [W-1:0] v,
                                       input logic [W-1:0] s,
                                       input logic [W-1:0] ka,
                                       input logic [W-1:0] kb);
    return ((v << SHL) + ka) ^ (v + s) ^ ((v >> SHR) + kb);
  endfunction

  // One TEA round in each direction; mode selects which result is used.
  always_comb begin
    esum = sum_q + delta_q;
    ex   = x_q + mix(y_q, esum, k0, k1);
    ey   = y_q + mix(ex, esum, k2, k3);
    dy   = y_q - mix(x_q, sum_q, k2, k3);
    dx   = x_q - mix(dy, sum_q, k0, k1);
    dsum = sum_q - delta_q;
    rx   = mode_q ? dx : ex;
    ry   = mode_q ? dy : ey;
    rsum = mode_q ? dsum : esum;
  end

  // Next-state, datapath and output-register control.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sum_d    = sum_q;
    delta_d  = delta_q;
    key_d    = key_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    ov_d     = ov_q;
    out_free = !ov_q || bus.out_ready;

    // A pop with no load clears the slot; a load below overrides this.
    if (ov_q && bus.out_ready) ov_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_data[W-1:0];
          y_d     = bus.in_data[2*W-1:W];
          key_d   = bus.key;
          delta_d = bus.delta;
          mode_d  = bus.mode;
          cnt_d   = 8'd1 << bus.round;
          sum_d   = bus.mode ? (bus.delta << bus.round) : '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x_d   = rx;
        y_d   = ry;
        sum_d = rsum;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          if (out_free) begin
            out_d   = {ry, rx};
            ov_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (out_free) begin
          out_d   = {y_q, x_q};
          ov_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      delta_q <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      delta_q <= delta_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = out_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_WAIT);

endmodule

// File: tb/tb_tea_cipher_core.sv
// Self-checking bench for tea_cipher_core (W=32 and W=16 instances).
module tb_tea_cipher_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  tea_cipher_core_if #(.W(32)) a ();
  tea_cipher_core_if #(.W(16)) b ();

  tea_cipher_core #(.W(32), .SHL(4), .SHR(5)) dut32 (.clk(clk), .rst(rst), .bus(a));
  tea_cipher_core #(.W(16), .SHL(4), .SHR(5)) dut16 (.clk(clk), .rst(rst), .bus(b));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned mix(input longint unsigned v, input longint unsigned s,
                                          input longint unsigned ka, input longint unsigned kb,
                                          input longint unsigned m);
    return (((((v << 4) & m) + ka) & m) ^ ((v + s) & m) ^ (((v >> 5) + kb) & m)) & m;
  endfunction

  // Plain TEA on w-bit halves: N = 2**rnd rounds, decrypt starts from delta*N.
  function automatic logic [63:0] tea_model(input int w, input bit dec, input int rnd,
                                            input longint unsigned dl, input logic [127:0] ky,
                                            input logic [63:0] blk);
    longint unsigned m, x, y, s, n, d;
    longint unsigned k[4];
    m = (64'd1 << w) - 64'd1;
    d = dl & m;
    x = blk & m;
    y = (blk >> w) & m;
    for (int i = 0; i < 4; i++) k[i] = 64'(ky >> (i * w)) & m;
    n = 64'd1 << rnd;
    s = dec ? (d * n) & m : 64'd0;
    for (longint unsigned r = 0; r < n; r++) begin
      if (!dec) begin
        s = (s + d) & m;
        x = (x + mix(y, s, k[0], k[1], m)) & m;
        y = (y + mix(x, s, k[2], k[3], m)) & m;
      end else begin
        y = (y - mix(x, s, k[2], k[3], m)) & m;
        x = (x - mix(y, s, k[0], k[1], m)) & m;
        s = (s - d) & m;
      end
    end
    return 64'((y << w) | x);
  endfunction

  // Present a block on the 32-bit core and hold it until accepted; after the
  // accept edge the config inputs are scrambled to prove only latched copies matter.
  task automatic send_a(input bit md, input logic [2:0] rnd, input logic [31:0] dl,
                        input logic [127:0] ky, input logic [63:0] dat);
    int t;
    @(negedge clk);
    a.mode = md; a.round = rnd; a.delta = dl; a.key = ky; a.in_data = dat; a.in_valid = 1'b1;
    t = 0;
    while (!a.in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    a.in_valid = 1'b0;
    a.mode  = ~md;
    a.round = 3'($urandom);
    a.delta = $urandom;
    a.key   = {$urandom, $urandom, $urandom, $urandom};
    a.in_data = {$urandom, $urandom};
  endtask

  // Run one unstalled block; lat counts rising edges from the accept edge
  // (inclusive) up to the edge that raises out_valid.
  task automatic run_a(input bit md, input logic [2:0] rnd, input logic [31:0] dl,
                       input logic [127:0] ky, input logic [63:0] dat,
                       output logic [63:0] res, output int lat);
    a.out_ready = 1'b1;
    send_a(md, rnd, dl, ky, dat);
    lat = 1;
    while (lat < 400) begin
      @(negedge clk);
      if (a.out_valid) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 400) check("result_timeout", 1, 0);
    res = a.out_data;
  endtask

  initial begin
    logic [63:0]  res, back, pt, pa, pb;
    logic [127:0] ky;
    logic [31:0]  dl;
    logic [2:0]   rnd;
    int           lat;
    bit           seen;

    a.mode = 0; a.round = 0; a.delta = 0; a.key = 0; a.in_valid = 0; a.in_data = 0; a.out_ready = 0;
    b.mode = 0; b.round = 0; b.delta = 0; b.key = 0; b.in_valid = 0; b.in_data = 0; b.out_ready = 0;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", a.out_valid, 0);
    check("rst_out_data", a.out_data, 0);
    check("rst_busy", a.busy, 0);
    check("rst_in_ready", a.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", a.in_ready, 1);

    // Known-answer encrypt, then decrypt back
    run_a(0, 3'd5, 32'h9E3779B9, '0, '0, res, lat);
    check("kat_enc", res, 64'h94BAA940_41EA3A0A);
    check("kat_model", res, tea_model(32, 0, 5, 64'h9E3779B9, '0, '0));
    check("kat_lat", lat, 33);
    run_a(1, 3'd5, 32'h9E3779B9, '0, 64'h94BAA940_41EA3A0A, res, lat);
    check("kat_dec", res, 0);
    check("kat_dec_lat", lat, 33);

    // Random round trips against the model
    for (int i = 0; i < 200; i++) begin
      ky  = {$urandom, $urandom, $urandom, $urandom};
      dl  = $urandom;
      rnd = 3'($urandom_range(0, 7));
      pt  = {$urandom, $urandom};
      run_a(0, rnd, dl, ky, pt, res, lat);
      check("rnd_enc", res, tea_model(32, 0, int'(rnd), 64'(dl), ky, pt));
      if (i < 8) check("rnd_lat", lat, (1 << rnd) + 1);
      run_a(1, rnd, dl, ky, res, back, lat);
      check("rnd_dec", back, pt);
    end

    // Back-to-back with the output stalled
    ky = {$urandom, $urandom, $urandom, $urandom};
    dl = $urandom;
    pa = {$urandom, $urandom};
    pb = {$urandom, $urandom};
    @(negedge clk);
    a.out_ready = 1'b0;
    send_a(0, 3'd1, dl, ky, pa);
    send_a(0, 3'd1, dl, ky, pb);
    repeat (10) @(negedge clk);
    check("stall_out_valid", a.out_valid, 1);
    check("stall_first_data", a.out_data, tea_model(32, 0, 1, 64'(dl), ky, pa));
    check("stall_busy", a.busy, 1);
    check("stall_in_ready", a.in_ready, 0);
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
    check("swap_out_valid", a.out_valid, 1);
    check("swap_second_data", a.out_data, tea_model(32, 0, 1, 64'(dl), ky, pb));
    check("swap_busy", a.busy, 0);
    check("swap_in_ready", a.in_ready, 1);
    a.out_ready = 1'b1;
    @(negedge clk);
    check("drain_out_valid", a.out_valid, 0);

    // Reset in the middle of a 32-round block
    send_a(0, 3'd5, 32'h9E3779B9, ky, pa);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("midrst_in_ready", a.in_ready, 0);
    check("midrst_out_valid", a.out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", a.out_valid, 0);
    check("post_rst_in_ready", a.in_ready, 1);
    check("post_rst_busy", a.busy, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (a.out_valid) seen = 1;
    end
    check("post_rst_no_output", seen, 0);
    run_a(0, 3'd2, dl, ky, pb, res, lat);
    check("post_rst_block", res, tea_model(32, 0, 2, 64'(dl), ky, pb));

    // W=16 single-round case
    @(negedge clk);
    b.mode = 0; b.round = 3'd0; b.delta = 16'h9E37; b.key = 64'h0004_0003_0002_0001;
    b.in_data = 32'h0001_0000; b.out_ready = 1'b1; b.in_valid = 1'b1;
    check("w16_in_ready", b.in_ready, 1);
    @(posedge clk);
    #1;
    b.in_valid = 1'b0; b.mode = 1'b1; b.delta = 16'h1234; b.key = {$urandom, $urandom};
    lat = 1;
    while (lat < 50) begin
      @(negedge clk);
      if (b.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("w16_lat", lat, 2);
    check("w16_res", b.out_data, 32'hDA25_9E2B);
    check("w16_model", b.out_data, 32'(tea_model(16, 0, 0, 64'h9E37, 128'h0004_0003_0002_0001, 64'h0001_0000)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tea_cipher_core.md
Name: tea_cipher_core

Overview:
- Parametrised iterative TEA block cipher core. Successor of the fixed 16-bit encrypt-only engine.
- Half-word width is generic, and encrypt or decrypt is selected per block.
- Uses valid/ready handshakes on input and output, plus a one-entry output register so a new block can run while the previous result waits.
- Sits between the bus-side data mover and the key/config registers; computes one round per clock.

Parameters:
W, 32, half-block width in bits (block = 2W, key = 4W)
SHL, 4, left shift amount in round function
SHR, 5, right shift amount in round function

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
mode  input  1  0 = encrypt, 1 = decrypt; sampled on input accept
round  input  3  log2 of round count; rounds N = 1<<round (1..128); sampled on accept
delta  input  W  key-schedule constant; sampled on accept
key  input  4W  {k3,k2,k1,k0}, k0 in LSBs; sampled on accept
in_valid  input  1  in_data valid
in_ready  output  1  core can accept a block
in_data  input  2W  {y,x}, x = low half
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream takes result
out_data  output  2W  {y,x} result
busy  output  1  high in RUN or WAIT

Behaviour:
- Reset (async, rst=1) values:
  - state = IDLE; out_valid = 0; out_data = 0; busy = 0; in_ready = 0 while rst is high.
  - Reset mid-operation aborts the block; no output is produced.
- States:
  - IDLE: in_ready = 1. On in_valid&in_ready, latch x, y, key, delta, mode; set count = N; set sum = 0 (enc) or delta<<round truncated to W (dec). Next state RUN.
  - RUN: in_ready = 0. One round per cycle; count decrements.
    - Enc: sum += delta; x += ((y<<SHL)+k0) ^ (y+sum) ^ ((y>>SHR)+k1); y += ((x'<<SHL)+k2) ^ (x'+sum) ^ ((x'>>SHR)+k3), where x' is the updated x.
    - Dec: y -= ((x<<SHL)+k2) ^ (x+sum) ^ ((x>>SHR)+k3); x -= ((y'<<SHL)+k0) ^ (y'+sum) ^ ((y'>>SHR)+k1); then sum -= delta.
    - All arithmetic is modulo 2^W; shifts are logical.
  - At the final round (count==1), the result goes to out_data if the output register is free (out_valid=0, or out_ready=1 this cycle). In that case out_valid <= 1 and next state is IDLE. Otherwise next state is WAIT, with the result held in x and y.
  - WAIT: in_ready = 0. When out_valid=0 or out_ready=1, load out_data, set out_valid <= 1, go to IDLE.
- Output handshake:
  - out_valid clears on out_ready when no new result is loaded the same cycle.
  - A simultaneous pop and load keeps out_valid = 1 with the new data.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: accept at cycle 0; out_valid rises at cycle N+1 when unstalled. Throughput is one block per N+1 cycles.
- Config ports may change freely after accept; only the latched copies are used.
- in_valid while not in_ready is ignored; no data loss, because the source must hold its data.
- round=0 gives a single-round operation.

Test Plan:
- W=32, key=0, delta=0x9E3779B9, round=5, mode=0, in_data=0 -> out_data=0x94BAA940_41EA3A0A; out_valid rises 33 cycles after accept.
- Same config with mode=1 and in_data=0x94BAA940_41EA3A0A -> out_data=0. Repeat for 200 random key/data/round sets: enc then dec returns the original plaintext.
- Back-to-back blocks, out_ready held 0: the first result waits in out_data; the second reaches WAIT with busy=1 and in_ready=0. Raise out_ready for 1 cycle -> second result loads the same cycle, out_valid stays 1, state returns to IDLE.
- Assert rst for 1 cycle mid-RUN (round 10 of 32) -> out_valid=0, in_ready=1 after release. The next block gives the correct result with no leftover state.
- round=0, mode=0, W=16, delta=0x9E37, key=0x0004_0003_0002_0001, in_data=0x0001_0000 -> result matches the single-round reference model; out_valid 2 cycles after accept.
- Change key, delta and mode during RUN -> result equals the value computed with the parameters latched at accept.
